// File: rtl/lzc_arb_pkg.sv
// -----------------------------------------------------------------------------
// lzc_arb_pkg
// Shared helpers for the lzc_arbiter block.
//   lzc_latency(size)         : pipeline depth of pipe_lzc_core. It is the
//                               number of levels in a 4-way reduction tree
//                               covering 'size' bits (64 -> 3, 16 -> 2, 4 -> 1).
//   rsp_entry_w(out_size,id_w): width of one response entry. The entry is a
//                               packed {count, zero, id}, declared in the
//                               user's scope because its field widths depend
//                               on parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package lzc_arb_pkg;

  function automatic int lzc_latency(input int size);
    int     lvl;
    longint span;
    lvl  = 0;
    span = 1;
    while (span < longint'(size)) begin
      span = span * 4;
      lvl  = lvl + 1;
    end
    return lvl;
  endfunction

  function automatic int rsp_entry_w(input int out_size, input int id_w);
    return out_size + 1 + id_w;
  endfunction

endpackage

// File: rtl/lzc_arbiter_if.sv
// -----------------------------------------------------------------------------
// lzc_arbiter_if
// Request and response bus of lzc_arbiter.
//   req_valid/req_ready : per-requester handshake; req_ready is one-hot or zero
//   req_data            : NREQ packed operands; requester i at [i*SIZE +: SIZE]
//   rsp_valid/rsp_ready : response handshake (show-ahead head entry)
//   rsp_count/rsp_zero/rsp_id : head entry fields
// Modports:
//   slave  - the arbiter side
//   master - the requester/consumer side
// -----------------------------------------------------------------------------
interface lzc_arbiter_if #(
  parameter int SIZE = 64,
  parameter int NREQ = 4
);
  localparam int OUT_SIZE = $clog2(SIZE + 1);
  localparam int ID_W     = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_SIZE-1:0]  rsp_count;
  logic                 rsp_zero;
  logic [ID_W-1:0]      rsp_id;

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_count, rsp_zero, rsp_id
  );

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_count, rsp_zero, rsp_id
  );
endinterface

// File: rtl/lzc_arb_fifo.sv
// -----------------------------------------------------------------------------
// lzc_arb_fifo
// Synchronous show-ahead FIFO with a registered output stage.
// Entries are written into a RAM array. The head is moved into an output
// register through a registered read. Total capacity is DEPTH, counting the
// RAM contents and the output register together. Data appears on data_o one
// cycle after the push edge.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (pointers/outputs)
//   push_i         : write push_data_i
//   push_data_i    : entry to write
//   pop_i          : consumer ready; a pop happens only when valid_o is high
//   valid_o        : head entry present on data_o
//   data_o         : head entry (registered)
// -----------------------------------------------------------------------------
module lzc_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q;
  logic             pop, load, full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Refill the output register when it is empty or is being popped.
  assign pop  = valid_q && pop_i;
  assign load = (mem_cnt_q != '0) && (!valid_q || pop);
  assign full = ({1'b0, mem_cnt_q} + (CNT_W+1)'(valid_q)) == (CNT_W+1)'(DEPTH);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    valid_d   = valid_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (load)   rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, load})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
    if (load)     valid_d = 1'b1;
    else if (pop) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      valid_q   <= valid_d;
      if (load) data_q <= mem[rd_ptr_q];
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

  // The upstream credit scheme must make overflow impossible.
  assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/pipe_lzc_core.sv
// -----------------------------------------------------------------------------
// pipe_lzc_core
// Leading-zero counter (MSB first) with a fixed latency of LATENCY registers.
// The core never stalls and has no reset. Its output is meaningful only when
// the caller's own tag says so.
// For FAMILY "Agilex" the count is formed at the input and the register chain
// follows it, so retiming can pull the registers back into the count logic.
// For other families the operand is registered first and counted at the
// output.
// Ports:
//   clk  : clock
//   din  : operand
//   dout : count of leading zeros of din from LATENCY cycles earlier
//          (equals SIZE for an all-zero operand)
// -----------------------------------------------------------------------------
module pipe_lzc_core #(
  parameter int    SIZE     = 64,
  parameter int    OUT_SIZE = $clog2(SIZE + 1),
  parameter int    LATENCY  = 3,
  parameter string FAMILY   = "Agilex"
) (
  input  logic                clk,
  input  logic [SIZE-1:0]     din,
  output logic [OUT_SIZE-1:0] dout
);
  function automatic logic [OUT_SIZE-1:0] lzc(input logic [SIZE-1:0] v);
    logic [OUT_SIZE-1:0] c;
    c = OUT_SIZE'(SIZE);
    // The highest set bit is visited last, so it determines the result.
    for (int i = 0; i < SIZE; i++) begin
      if (v[i]) c = OUT_SIZE'(SIZE - 1 - i);
    end
    return c;
  endfunction

  if (FAMILY == "Agilex") begin : g_out_retime
    logic [OUT_SIZE-1:0] cnt_q [LATENCY];
    logic [OUT_SIZE-1:0] cnt_d [LATENCY];
    always_comb begin
      for (int i = 0; i < LATENCY; i++) cnt_d[i] = (i == 0) ? lzc(din) : cnt_q[(i == 0) ? 0 : i - 1];
    end
    always_ff @(posedge clk) begin
      for (int i = 0; i < LATENCY; i++) cnt_q[i] <= cnt_d[i];
    end
    assign dout = cnt_q[LATENCY-1];
  end else begin : g_in_retime
    logic [SIZE-1:0] opd_q [LATENCY];
    logic [SIZE-1:0] opd_d [LATENCY];
    always_comb begin
      for (int i = 0; i < LATENCY; i++) opd_d[i] = (i == 0) ? din : opd_q[(i == 0) ? 0 : i - 1];
    end
    always_ff @(posedge clk) begin
      for (int i = 0; i < LATENCY; i++) opd_q[i] <= opd_d[i];
    end
    assign dout = lzc(opd_q[LATENCY-1]);
  end

endmodule

// File: rtl/lzc_arbiter.sv
// -----------------------------------------------------------------------------
// lzc_arbiter
// Shares one pipelined leading-zero counter between NREQ requesters.
// A round-robin arbiter issues at most one operation per cycle. A tag pipe
// carries each operation's requester id alongside the core. Results land in a
// show-ahead response FIFO. Credits track free FIFO slots minus in-flight
// operations, so the core never has to stall.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : lzc_arbiter_if.slave (request and response handshakes)
//   stat_issued  : saturating count of issued operations
//   stat_stall   : saturating count of cycles with a request pending and no credit
// Build option: define LZC_ARBITER_STATS_EN to build the two counters.
// Without it, both stat ports read 0.
// -----------------------------------------------------------------------------
module lzc_arbiter
  import lzc_arb_pkg::*;
#(
  parameter int    SIZE        = 64,
  parameter int    OUT_SIZE    = $clog2(SIZE + 1),
  parameter int    NREQ        = 4,
  parameter int    ID_W        = $clog2(NREQ),
  parameter int    LZC_LATENCY = lzc_latency(SIZE),
  parameter int    FIFO_DEPTH  = 4,
  parameter string FAMILY      = "Agilex"
) (
  input  logic              clk,
  input  logic              rst,
  lzc_arbiter_if.slave      bus,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall
);
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int RSP_W  = rsp_entry_w(OUT_SIZE, ID_W);

  typedef struct packed {
    logic [OUT_SIZE-1:0] count;
    logic                zero;
    logic [ID_W-1:0]     id;
  } rsp_t;

  logic [CRED_W-1:0]   credits_q, credits_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_found;
  logic [NREQ-1:0]     grant_vec;
  logic                issue, pop;
  logic [SIZE-1:0]     core_din;
  logic [OUT_SIZE-1:0] core_dout;
  logic                tag_vld_q [LZC_LATENCY];
  logic                tag_vld_d [LZC_LATENCY];
  logic [ID_W-1:0]     tag_id_q  [LZC_LATENCY];
  logic [ID_W-1:0]     tag_id_d  [LZC_LATENCY];
  rsp_t                push_entry, rsp_head;
  logic                push;

  // Round-robin search: the first valid requester at or after rr_ptr, with
  // wrap-around modulo NREQ.
  always_comb begin : arb_search
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    sum         = '0;
    idx         = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      idx = sum[ID_W-1:0];
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (!rst && grant_found && (credits_q != '0)) grant_vec[grant_idx] = 1'b1;
  end

  assign bus.req_ready = grant_vec;
  assign issue         = |(bus.req_valid & grant_vec);
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  // Idle cycles feed zero into the core. That result is dropped because its
  // tag is invalid.
  always_comb begin
    core_din = '0;
    if (issue) core_din = bus.req_data[grant_idx*SIZE +: SIZE];
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    credits_d = credits_q;
    if (issue) rr_ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
    case ({issue, pop})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Tag pipe: stage i holds the tag of the operand that entered the core i+1
  // edges ago.
  always_comb begin
    for (int i = 0; i < LZC_LATENCY; i++) begin
      tag_vld_d[i] = (i == 0) ? issue     : tag_vld_q[(i == 0) ? 0 : i - 1];
      tag_id_d[i]  = (i == 0) ? grant_idx : tag_id_q[(i == 0) ? 0 : i - 1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q <= CRED_W'(FIFO_DEPTH);
      rr_ptr_q  <= '0;
      for (int i = 0; i < LZC_LATENCY; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      credits_q <= credits_d;
      rr_ptr_q  <= rr_ptr_d;
      for (int i = 0; i < LZC_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_d[i];
        tag_id_q[i]  <= tag_id_d[i];
      end
    end
  end

  pipe_lzc_core #(
    .SIZE     (SIZE),
    .OUT_SIZE (OUT_SIZE),
    .LATENCY  (LZC_LATENCY),
    .FAMILY   (FAMILY)
  ) u_core (
    .clk  (clk),
    .din  (core_din),
    .dout (core_dout)
  );

  assign push             = tag_vld_q[LZC_LATENCY-1];
  assign push_entry.count = core_dout;
  assign push_entry.zero  = (core_dout == OUT_SIZE'(SIZE));
  assign push_entry.id    = tag_id_q[LZC_LATENCY-1];

  lzc_arb_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (bus.rsp_ready),
    .valid_o     (bus.rsp_valid),
    .data_o      (rsp_head)
  );

  assign bus.rsp_count = rsp_head.count;
  assign bus.rsp_zero  = rsp_head.zero;
  assign bus.rsp_id    = rsp_head.id;

`ifdef LZC_ARBITER_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (issue && (stat_issued_q != '1)) stat_issued_d = stat_issued_q + 32'd1;
    if ((|bus.req_valid) && (credits_q == '0) && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_lzc_arbiter.sv
module tb_lzc_arbiter;
  localparam int SIZE  = 64;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stat_issued, stat_stall;

  always #5 clk = ~clk;

  lzc_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

  lzc_arbiter #(
    .SIZE        (SIZE),
    .NREQ        (NREQ),
    .LZC_LATENCY (LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
  );

  typedef struct {
    int id;
    int cnt;
    bit zero;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   exp_cnt [NREQ];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: log grants into the scoreboard and compare every popped response.
  initial begin : monitor
    logic [NREQ-1:0] gmask;
    exp_t            e;
    int              g;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            $display("rsp  id=%0d count=%0d zero=%0d", bus.rsp_id, bus.rsp_count, bus.rsp_zero);
            check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
            check("rsp_count", 64'(bus.rsp_count), 64'(e.cnt));
            check("rsp_zero", 64'(bus.rsp_zero), 64'(e.zero));
          end
        end
        gmask = bus.req_valid & bus.req_ready;
        if (gmask != '0) begin
          check("grant_onehot", 64'($countones(gmask)), 64'd1);
          g = 0;
          for (int i = 0; i < NREQ; i++) if (gmask[i]) g = i;
          grant_log.push_back(g);
          sb.push_back('{id: g, cnt: exp_cnt[g], zero: (exp_cnt[g] == SIZE)});
          $display("issue id=%0d expect_count=%0d", g, exp_cnt[g]);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic set_data(input int r, input logic [SIZE-1:0] d, input int ec);
    exp_cnt[r] = ec;
    bus.req_data[r*SIZE +: SIZE] = d;
  endtask

  // One lone request; checks the grant and the exact response latency.
  task automatic single_op(input int r, input logic [SIZE-1:0] d, input int ec);
    int t;
    @(posedge clk); #2;
    set_data(r, d, ec);
    bus.req_valid = NREQ'(1) << r;
    @(negedge clk);
    check("single_grant", 64'(bus.req_ready), 64'(NREQ'(1) << r));
    @(posedge clk); #2;                        // issue edge just passed
    bus.req_valid = '0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.rsp_valid && t < 20);
    // Valid first seen after the 4th edge following the issue edge.
    check("single_latency", 64'(t), 64'(LAT + 2));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin : stimulus
    int  t;
    bit  saw_valid;
    int  exp_rr [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    int  exp_bp [5] = '{3, 0, 1, 2, 3};
    logic [31:0] iss0, stl0;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_cnt[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_count", 64'(bus.rsp_count), 64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("rst_rsp_zero",  64'(bus.rsp_zero),  64'd0);
    check("rst_credits",   64'(dut.credits_q), 64'(DEPTH));
    check("rst_rr_ptr",    64'(dut.rr_ptr_q),  64'd0);
    check("rst_stat_issued", 64'(stat_issued), 64'd0);
    @(posedge clk); #2;
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;

    // Single operations: bit 32 set -> 31; all-zero -> 64 with zero flag.
    single_op(0, 64'h0000_0001_0000_0000, 31);
    single_op(2, 64'h0, 64);
    drain();
    repeat (3) @(negedge clk);
    check("idle_ready_credits", 64'(dut.credits_q), 64'(DEPTH));

    // Round robin with all requesters active; rr_ptr is 3 after the grants to 0 and 2.
    set_data(0, 64'h8000_0000_0000_0000, 0);
    set_data(1, 64'h0000_0000_0000_00FF, 56);
    set_data(2, 64'h0001_0000_0000_0000, 15);
    set_data(3, 64'h0000_0000_8000_0000, 32);
    @(posedge clk); #2;
    grant_log.delete();
    bus.req_valid = 4'b1111;
    t = 0;
    while (grant_log.size() < 8 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    bus.req_valid = '0;
    check("rr_grant_total", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      check("rr_grant_order", 64'(grant_log[k]), 64'(exp_rr[k]));
    drain();

    // Backpressure: exactly DEPTH issues, then the credits run out.
    @(posedge clk); #2;
    grant_log.delete();
    bus.rsp_ready = 1'b0;
    iss0 = stat_issued;
    stl0 = stat_stall;
    bus.req_valid = 4'b1111;
    repeat (10) begin
      @(posedge clk); #2;
    end
    check("bp_issue_count", 64'(grant_log.size()), 64'(DEPTH));
    check("bp_req_ready",   64'(bus.req_ready),    64'd0);
    check("bp_credits",     64'(dut.credits_q),    64'd0);
`ifdef LZC_ARBITER_STATS_EN
    check("bp_stat_issued", 64'(stat_issued - iss0), 64'd4);
    check("bp_stat_stall",  64'(stat_stall - stl0),  64'd6);
`else
    check("bp_stat_issued_off", 64'(stat_issued), 64'd0);
    check("bp_stat_stall_off",  64'(stat_stall),  64'd0);
`endif
    bus.rsp_ready = 1'b1;
    @(negedge clk);                            // cycle of the first pop
    check("bp_no_issue_on_pop", 64'(bus.req_ready), 64'd0);
    @(negedge clk);                            // credit usable now
    check("bp_resume_grant", 64'(bus.req_ready), 64'b1000);
    @(posedge clk); #2;
    bus.req_valid = '0;
    check("bp_grant_total", 64'(grant_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("bp_grant_order", 64'(grant_log[k]), 64'(exp_bp[k]));
    drain();

    // Reset with two operations in flight.
    set_data(0, 64'h0000_0000_0000_0001, 63);
    set_data(1, 64'h0000_0000_0000_0002, 62);
    @(posedge clk); #2;
    bus.req_valid = 4'b0011;
    @(posedge clk); #2;
    @(posedge clk); #2;
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_valid = 1'b1;
    end
    check("post_rst_quiet",   64'(saw_valid),      64'd0);
    check("post_rst_credits", 64'(dut.credits_q),  64'(DEPTH));
    check("post_rst_rr_ptr",  64'(dut.rr_ptr_q),   64'd0);
    single_op(1, 64'h0000_0000_0000_0100, 55);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
